// File: rtl/audio_period_meter.sv
// audio_period_meter
//
// Measures the fundamental period of a signed 32-bit audio sample stream.
// Rising zero crossings are detected with hysteresis, the cycle distance
// between them is accumulated over 2^AVG_LOG2 periods, and the average is
// reported.
//
// Parameters:
//   HYSTERESIS  threshold magnitude; >= +HYSTERESIS is high, <= -HYSTERESIS is low
//   TIMEOUT     max cycles between rising edges before lock is dropped
//   AVG_LOG2    log2 of the number of periods averaged (0..4)
//
// Ports:
//   CLOCK_50      in   system clock
//   reset         in   synchronous, active-high reset
//   in_sample     in   [31:0] signed two's-complement audio sample
//   in_valid      in   in_sample is valid this cycle
//   period        out  [31:0] averaged period in cycles, 0 when not locked
//   period_valid  out  one-cycle pulse when period is updated
//   locked        out  a full average has been produced since last timeout/reset
//   polarity      out  1 = signal high, 0 = low or unknown
//
// Handshake: in_valid qualifies in_sample for one cycle; there is no ready,
// every valid sample is consumed. period_valid is a one-cycle strobe with no
// back-pressure.
module audio_period_meter #(
    parameter logic [31:0] HYSTERESIS = 32'd1_000_000,
    parameter logic [31:0] TIMEOUT    = 32'd50_000_000,
    parameter int          AVG_LOG2   = 2
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic [31:0] in_sample,
    input  logic        in_valid,
    output logic [31:0] period,
    output logic        period_valid,
    output logic        locked,
    output logic        polarity
);

    localparam int SUM_W  = 32 + AVG_LOG2;
    localparam int NPER_W = AVG_LOG2 + 1;
    localparam logic [NPER_W-1:0] NPER_FULL = NPER_W'(2 ** AVG_LOG2);
    localparam logic signed [31:0] HYST_POS = signed'(HYSTERESIS);
    localparam logic signed [31:0] HYST_NEG = -HYST_POS;

    typedef enum logic [1:0] {
        POL_UNKNOWN = 2'd0,
        POL_HIGH    = 2'd1,
        POL_LOW     = 2'd2
    } pol_state_t;

    typedef enum logic {
        MEAS_SEARCH  = 1'b0,
        MEAS_MEASURE = 1'b1
    } meas_state_t;

    pol_state_t        pol_state;
    meas_state_t       meas_state;
    logic              rise;        // high in the cycle polarity has just gone LOW->HIGH
    logic [31:0]       cnt;
    logic [SUM_W-1:0]  sum;
    logic [NPER_W-1:0] nper;

    logic              sample_high;
    logic              sample_low;
    logic              timeout_hit;
    logic [SUM_W-1:0]  sum_next;
    logic [NPER_W-1:0] nper_next;

    assign sample_high = in_valid && ($signed(in_sample) >= HYST_POS);
    assign sample_low  = in_valid && ($signed(in_sample) <= HYST_NEG);
    // An edge arriving on the same cycle as cnt == TIMEOUT takes priority.
    assign timeout_hit = (meas_state == MEAS_MEASURE) && !rise && (cnt == TIMEOUT);
    assign sum_next    = sum + SUM_W'(cnt);
    assign nper_next   = nper + NPER_W'(1);
    assign polarity    = (pol_state == POL_HIGH);

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            pol_state    <= POL_UNKNOWN;
            rise         <= 1'b0;
            meas_state   <= MEAS_SEARCH;
            cnt          <= '0;
            sum          <= '0;
            nper         <= '0;
            period       <= '0;
            period_valid <= 1'b0;
            locked       <= 1'b0;
        end else begin
            period_valid <= 1'b0;

            // Polarity FSM. A timeout forces UNKNOWN so the next edge must be
            // preceded by a fresh low excursion.
            if (timeout_hit) begin
                pol_state <= POL_UNKNOWN;
                rise      <= 1'b0;
            end else if (sample_high) begin
                pol_state <= POL_HIGH;
                rise      <= (pol_state == POL_LOW);
            end else if (sample_low) begin
                pol_state <= POL_LOW;
                rise      <= 1'b0;
            end else begin
                rise      <= 1'b0;
            end

            // Measurement FSM.
            if (meas_state == MEAS_SEARCH) begin
                if (rise) begin
                    cnt        <= 32'd1;
                    sum        <= '0;
                    nper       <= '0;
                    meas_state <= MEAS_MEASURE;
                end
            end else begin
                if (rise) begin
                    // The edge that closes a block also opens the next one.
                    cnt <= 32'd1;
                    if (nper_next == NPER_FULL) begin
                        period       <= 32'(sum_next >> AVG_LOG2);
                        period_valid <= 1'b1;
                        locked       <= 1'b1;
                        sum          <= '0;
                        nper         <= '0;
                    end else begin
                        sum  <= sum_next;
                        nper <= nper_next;
                    end
                end else if (timeout_hit) begin
                    meas_state <= MEAS_SEARCH;
                    locked     <= 1'b0;
                    period     <= '0;
                    sum        <= '0;
                    nper       <= '0;
                    cnt        <= '0;
                end else begin
                    cnt <= cnt + 32'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_audio_period_meter.sv
// Testbench for audio_period_meter. Uses a shortened TIMEOUT so lock loss
// fits in a short run. The reference model tracks the input's qualified side
// and the cycle index of every rising crossing; expected periods are plain
// differences between crossing cycles.
module tb_audio_period_meter;
  localparam logic [31:0] HYST = 32'd1_000_000;
  localparam int H    = 1_000_000;
  localparam int TMO  = 3000;
  localparam int AVG  = 2;
  localparam int NPER = 1 << AVG;

  logic        CLOCK_50 = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] in_sample = '0;
  logic        in_valid = 1'b0;
  logic [31:0] period;
  logic        period_valid;
  logic        locked;
  logic        polarity;

  audio_period_meter #(
    .HYSTERESIS(HYST),
    .TIMEOUT(32'(TMO)),
    .AVG_LOG2(AVG)
  ) dut (
    .CLOCK_50(CLOCK_50),
    .reset(reset),
    .in_sample(in_sample),
    .in_valid(in_valid),
    .period(period),
    .period_valid(period_valid),
    .locked(locked),
    .polarity(polarity)
  );

  // ---------------- clock / reset ----------------
  always #10 CLOCK_50 = ~CLOCK_50;

  int cyc = 0;
  int checks = 0;
  int passed = 0;
  int vcnt = 0;

  // ---------------- scoreboard: {cycle, period, locked} ----------------
  logic [64:0] exp_q[$];
  logic [64:0] obs_q[$];

  always @(negedge CLOCK_50)
    if (period_valid === 1'b1) obs_q.push_back({32'(cyc), period, locked});

  // ---------------- reference model ----------------
  int          m_side = 0;      // 0 unknown, 1 high, 2 low
  bit          m_meas = 0;
  int          m_start = 0;
  int          m_last = 0;
  int          m_n = 0;
  logic [31:0] m_period = '0;

  // ---------------- driver ----------------
  task automatic drive(input logic [31:0] s, input logic v, input logic r);
    int ss;
    int n;
    ss = s;
    n = cyc;
    in_sample = s;
    in_valid = v;
    reset = r;
    if (r) begin
      m_side = 0; m_meas = 0; m_period = '0;
    end else if (m_meas && (n - m_last == TMO + 1)) begin
      // no crossing for TIMEOUT cycles: lock lost, this sample is discarded
      m_side = 0; m_meas = 0; m_period = '0;
    end else if (v) begin
      if (ss >= H) begin
        if (m_side == 2) begin
          if (!m_meas) begin
            m_meas = 1; m_start = n; m_n = 0;
          end else begin
            m_n++;
            if (m_n == NPER) begin
              m_period = 32'((n - m_start) >> AVG);
              exp_q.push_back({32'(n + 2), m_period, 1'b1});
              m_start = n;
              m_n = 0;
            end
          end
          m_last = n;
        end
        m_side = 1;
      end else if (ss <= -H) begin
        m_side = 2;
      end
    end
    @(posedge CLOCK_50);
    #1;
    cyc++;
  endtask

  function automatic logic [31:0] hi_sample();
    if ($urandom_range(7) == 0) return HYST;
    return $urandom_range(32'h7FFF_FFFF, HYST);
  endfunction

  function automatic logic [31:0] lo_sample();
    logic [31:0] x;
    if ($urandom_range(7) == 0) return -HYST;
    x = $urandom_range(32'h7FFF_FFFF, HYST);
    return -x;
  endfunction

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) drive('0, 1'b0, 1'b1);
  endtask

  // drive len cycles at one level; valid only every 'every' cycles (garbage otherwise)
  task automatic drive_level(input bit high, input int len, input int every);
    logic v;
    for (int i = 0; i < len; i++) begin
      v = (every <= 1) || (vcnt % every == 0);
      vcnt++;
      drive(v ? (high ? hi_sample() : lo_sample()) : $urandom(), v, 1'b0);
    end
  endtask

  task automatic square(input int edges, input int half, input int every);
    for (int k = 0; k < edges; k++) begin
      drive_level(1'b1, half, every);
      drive_level(1'b0, half, every);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset(3);
    checks++; if (period !== 32'd0) $display("FAIL reset_period: got %0d expected 0", period); else passed++;
    checks++; if (period_valid !== 1'b0) $display("FAIL reset_pv: got %b expected 0", period_valid); else passed++;
    checks++; if (locked !== 1'b0) $display("FAIL reset_locked: got %b expected 0", locked); else passed++;
    checks++; if (polarity !== 1'b0) $display("FAIL reset_polarity: got %b expected 0", polarity); else passed++;
  endtask

  task automatic test_square();
    logic [64:0] o, e;
    do_reset(2);
    drive_level(1'b0, 300, 1);
    square(6, 200, 1);
    checks++; if (period !== 32'd400) $display("FAIL square_period: got %0d expected 400", period); else passed++;
    checks++; if (locked !== 1'b1) $display("FAIL square_locked: got %b expected 1", locked); else passed++;
    checks++; if (obs_q.size() != exp_q.size()) $display("FAIL square_count: got %0d expected %0d", obs_q.size(), exp_q.size()); else passed++;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      o = obs_q[i]; e = exp_q[i];
      checks++;
      if (o !== e) $display("FAIL square_pulse%0d: got cyc %0d per %0d lk %b expected cyc %0d per %0d lk %b", i, o[64:33], o[32:1], o[0], e[64:33], e[32:1], e[0]);
      else passed++;
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_random();
    logic [64:0] o, e;
    for (int k = 0; k < 16; k++) begin
      drive_level(1'b1, $urandom_range(400, 50), 1);
      checks++; if (polarity !== (m_side == 1)) $display("FAIL random_pol_hi%0d: got %b expected %b", k, polarity, m_side == 1); else passed++;
      drive_level(1'b0, $urandom_range(400, 50), 1);
      checks++; if (polarity !== (m_side == 1)) $display("FAIL random_pol_lo%0d: got %b expected %b", k, polarity, m_side == 1); else passed++;
    end
    checks++; if (period !== m_period) $display("FAIL random_period: got %0d expected %0d", period, m_period); else passed++;
    checks++; if (obs_q.size() != exp_q.size()) $display("FAIL random_count: got %0d expected %0d", obs_q.size(), exp_q.size()); else passed++;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      o = obs_q[i]; e = exp_q[i];
      checks++;
      if (o !== e) $display("FAIL random_pulse%0d: got cyc %0d per %0d lk %b expected cyc %0d per %0d lk %b", i, o[64:33], o[32:1], o[0], e[64:33], e[32:1], e[0]);
      else passed++;
    end
    exp_q.delete(); obs_q.delete();
  endtask

  // ramp inside the hysteresis band, crossing zero repeatedly
  task automatic test_dwell();
    logic        pol_before;
    logic [31:0] per_before;
    pol_before = polarity;
    per_before = period;
    for (int i = 0; i < 400; i++) drive(32'(((i % 200) - 100) * 9_999), 1'b1, 1'b0);
    drive(HYST - 32'd1, 1'b1, 1'b0);
    drive(-(HYST - 32'd1), 1'b1, 1'b0);
    checks++; if (polarity !== pol_before) $display("FAIL dwell_polarity: got %b expected %b", polarity, pol_before); else passed++;
    checks++; if (period !== per_before) $display("FAIL dwell_period: got %0d expected %0d", period, per_before); else passed++;
    checks++; if (obs_q.size() != 0) $display("FAIL dwell_pulses: got %0d expected 0", obs_q.size()); else passed++;
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_alternating();
    logic [64:0] o, e;
    do_reset(2);
    drive_level(1'b0, 600, 1);
    for (int k = 0; k < 6; k++) begin
      drive_level(1'b1, 500, 1);
      drive_level(1'b0, (k % 2 == 0) ? 500 : 503, 1);
    end
    checks++; if (period !== 32'd1001) $display("FAIL alt_period: got %0d expected 1001", period); else passed++;
    checks++; if (obs_q.size() != exp_q.size()) $display("FAIL alt_count: got %0d expected %0d", obs_q.size(), exp_q.size()); else passed++;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      o = obs_q[i]; e = exp_q[i];
      checks++;
      if (o !== e) $display("FAIL alt_pulse%0d: got cyc %0d per %0d lk %b expected cyc %0d per %0d lk %b", i, o[64:33], o[32:1], o[0], e[64:33], e[32:1], e[0]);
      else passed++;
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_timeout();
    logic [64:0] o, e;
    int last;
    do_reset(2);
    drive_level(1'b0, 300, 1);
    square(6, 200, 1);
    last = m_last;
    while (cyc < last + TMO + 1) drive('0, 1'b1, 1'b0);
    checks++; if (locked !== 1'b1) $display("FAIL timeout_early: locked %b expected 1", locked); else passed++;
    drive('0, 1'b1, 1'b0);
    checks++; if (locked !== 1'b0) $display("FAIL timeout_locked: got %b expected 0", locked); else passed++;
    checks++; if (period !== 32'd0) $display("FAIL timeout_period: got %0d expected 0", period); else passed++;
    checks++; if (polarity !== 1'b0) $display("FAIL timeout_polarity: got %b expected 0", polarity); else passed++;
    drive_level(1'b0, 300, 1);
    square(5, 200, 1);
    checks++; if (period !== 32'd400 || locked !== 1'b1) $display("FAIL relock: period %0d locked %b expected 400 1", period, locked); else passed++;
    checks++; if (obs_q.size() != exp_q.size()) $display("FAIL timeout_count: got %0d expected %0d", obs_q.size(), exp_q.size()); else passed++;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      o = obs_q[i]; e = exp_q[i];
      checks++;
      if (o !== e) $display("FAIL timeout_pulse%0d: got cyc %0d per %0d lk %b expected cyc %0d per %0d lk %b", i, o[64:33], o[32:1], o[0], e[64:33], e[32:1], e[0]);
      else passed++;
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_sparse_valid();
    logic [64:0] o, e;
    int diff;
    do_reset(2);
    vcnt = 0;
    drive_level(1'b0, 600, 13);
    square(6, 500, 13);
    diff = int'(period) - 1000;
    checks++; if (diff > 13 || diff < -13) $display("FAIL sparse_range: got %0d expected 1000 +-13", period); else passed++;
    checks++; if (obs_q.size() != exp_q.size()) $display("FAIL sparse_count: got %0d expected %0d", obs_q.size(), exp_q.size()); else passed++;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      o = obs_q[i]; e = exp_q[i];
      checks++;
      if (o !== e) $display("FAIL sparse_pulse%0d: got cyc %0d per %0d lk %b expected cyc %0d per %0d lk %b", i, o[64:33], o[32:1], o[0], e[64:33], e[32:1], e[0]);
      else passed++;
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_mid_reset();
    logic [64:0] o, e;
    do_reset(2);
    drive_level(1'b0, 300, 1);
    square(7, 200, 1);
    drive_level(1'b1, 100, 1);
    do_reset(1);
    checks++;
    if (period !== 32'd0 || period_valid !== 1'b0 || locked !== 1'b0 || polarity !== 1'b0)
      $display("FAIL midreset_outputs: got per %0d pv %b lk %b pol %b expected all 0", period, period_valid, locked, polarity);
    else passed++;
    drive_level(1'b1, 100, 1);
    drive_level(1'b0, 200, 1);
    square(4, 200, 1);
    checks++; if (locked !== 1'b0) $display("FAIL midreset_4edges: locked %b expected 0", locked); else passed++;
    square(1, 200, 1);
    checks++; if (locked !== 1'b1 || period !== 32'd400) $display("FAIL midreset_relock: lk %b per %0d expected 1 400", locked, period); else passed++;
    checks++; if (obs_q.size() != exp_q.size()) $display("FAIL midreset_count: got %0d expected %0d", obs_q.size(), exp_q.size()); else passed++;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      o = obs_q[i]; e = exp_q[i];
      checks++;
      if (o !== e) $display("FAIL midreset_pulse%0d: got cyc %0d per %0d lk %b expected cyc %0d per %0d lk %b", i, o[64:33], o[32:1], o[0], e[64:33], e[32:1], e[0]);
      else passed++;
    end
    exp_q.delete(); obs_q.delete();
  endtask

  // crossing exactly TIMEOUT cycles after the last one counts; one later does not
  task automatic test_edge_at_timeout();
    logic [64:0] o, e;
    int last;
    do_reset(2);
    drive_level(1'b0, 300, 1);
    drive_level(1'b1, 200, 1);
    last = m_last;
    while (cyc < last + TMO) drive(lo_sample(), 1'b1, 1'b0);
    drive_level(1'b1, 200, 1);
    drive_level(1'b0, 200, 1);
    square(3, 200, 1);
    checks++; if (period !== 32'd1050 || locked !== 1'b1) $display("FAIL edge_at_tmo: per %0d lk %b expected 1050 1", period, locked); else passed++;
    last = m_last;
    while (cyc < last + TMO + 1) drive(lo_sample(), 1'b1, 1'b0);
    drive_level(1'b1, 200, 1);
    checks++; if (locked !== 1'b0 || period !== 32'd0) $display("FAIL edge_after_tmo: lk %b per %0d expected 0 0", locked, period); else passed++;
    checks++; if (polarity !== 1'b1) $display("FAIL edge_after_tmo_pol: got %b expected 1", polarity); else passed++;
    checks++; if (obs_q.size() != exp_q.size()) $display("FAIL tmo_edge_count: got %0d expected %0d", obs_q.size(), exp_q.size()); else passed++;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      o = obs_q[i]; e = exp_q[i];
      checks++;
      if (o !== e) $display("FAIL tmo_edge_pulse%0d: got cyc %0d per %0d lk %b expected cyc %0d per %0d lk %b", i, o[64:33], o[32:1], o[0], e[64:33], e[32:1], e[0]);
      else passed++;
    end
    exp_q.delete(); obs_q.delete();
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_square();
    test_random();
    test_dwell();
    test_alternating();
    test_timeout();
    test_sparse_valid();
    test_mid_reset();
    test_edge_at_timeout();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/audio_period_meter.md
# audio_period_meter

Measures the fundamental period of an incoming signed 32-bit audio sample stream by detecting rising zero crossings with hysteresis and timing them in CLOCK_50 cycles. It sits on the consumer side of the audio path: it takes samples from a tone generator or the codec ADC, and reports an averaged period, a lock flag and the detected polarity. Its main uses are tone-generator self-check and pitch display.

## Interface
- HYSTERESIS, 32'd1_000_000: threshold magnitude. Samples at or above +HYSTERESIS count as high; samples at or below -HYSTERESIS count as low.
- TIMEOUT, 32'd50_000_000: maximum cycles between rising edges before lock is dropped (1 s).
- AVG_LOG2, 2: averaging over 2^AVG_LOG2 periods. Legal range 0..4.

- CLOCK_50  input  1  system clock, 50 MHz
- reset  input  1  reset, synchronous, active-high
- in_sample  input  32  signed two's-complement audio sample
- in_valid  input  1  in_sample is valid this cycle. May be held high every cycle.
- period  output  32  averaged period in CLOCK_50 cycles; 0 when not locked
- period_valid  output  1  one-cycle pulse when period is updated
- locked  output  1  a full average has been produced since the last timeout or reset
- polarity  output  1  detected signal state: 1 = high, 0 = low or unknown

## Operation
- Polarity FSM with states UNKNOWN, HIGH and LOW. Transitions are evaluated only when in_valid = 1.
  - Signed compare: sample ≥ +HYSTERESIS moves to HIGH.
  - Signed compare: sample ≤ -HYSTERESIS moves to LOW.
  - Otherwise the state holds.
  - UNKNOWN can move to HIGH or LOW.
- Rising edge event: the FSM transition LOW→HIGH only. UNKNOWN→HIGH is not an edge.
- Measurement FSM with states SEARCH and MEASURE:
  - SEARCH: cnt idle. A rising edge sets cnt = 1, sum = 0, nper = 0 and moves to MEASURE.
  - MEASURE: cnt increments every CLOCK_50 cycle, whether or not in_valid is high.
  - MEASURE, on a rising edge: sum += cnt, nper += 1, then cnt = 1.
  - When nper reaches 2^AVG_LOG2: period = sum >> AVG_LOG2 (truncated), period_valid pulses, locked = 1, sum = 0, nper = 0. Measurement continues without a gap; the edge that closes one block opens the next.
  - MEASURE, timeout: cnt == TIMEOUT on a cycle with no edge. Effects: go to SEARCH, locked = 0, period = 0, sum = 0, nper = 0, polarity FSM forced to UNKNOWN.
- Simultaneous edge and cnt == TIMEOUT: the edge wins and is accumulated normally.
- Widths:
  - cnt is 32 bits; it cannot wrap because of the timeout.
  - sum is 32 + AVG_LOG2 bits with no overflow.
  - The shift result is truncated to 32 bits.
- A reset asserted mid-measurement discards the partial sum. After reset, a fresh edge is required.

## Timing
- Reset values:
  - period = 0, period_valid = 0, locked = 0, polarity = 0.
  - Polarity FSM = UNKNOWN, measurement FSM = SEARCH, cnt = 0, sum = 0, nper = 0.
- Polarity latency: polarity reflects a qualifying sample on the cycle after it is presented with in_valid.
- Edge detection: a rising edge is recognized in the same cycle that the polarity register changes from 0 to 1. It does not wait for a further sample.
- The measured period equals the cycle distance between consecutive polarity 0→1 transitions.
- period_valid latency: the pulse and the new period appear one cycle after the edge that completes the block, i.e. 2 cycles after the sample.
- period holds its value between updates.
- locked:
  - Rises together with the first period_valid.
  - Falls on the cycle after the timeout condition.
- The block has no back-pressure. in_valid gaps only delay threshold crossings.

## Test plan
- Square wave at ±10_000_000, toggling every 56_819 cycles, starting negative, in_valid = 1 continuously, defaults → 1st period_valid 2 cycles after the 5th rising input crossing; period = 113_638; locked = 1.
- Sine-like ramp that dwells within ±HYSTERESIS and crosses 0 repeatedly without reaching ±1_000_000 → no edges, polarity stays at its prior state, period_valid never pulses.
- Lock at 113_638, then hold in_sample = 0 → exactly TIMEOUT cycles after the last edge: locked = 0, period = 0, polarity = 0. A new square wave relocks after 5 edges.
- AVG_LOG2 = 2 with alternating periods 1000 and 1003 cycles → period = (1000 + 1003 + 1000 + 1003) >> 2 = 1001.
- in_valid pulsing once every 1042 cycles (48 kHz), with a square wave of period 109_375 cycles → reported period within ±1042 of 109_375. Each edge is recognized exactly 1 cycle after the qualifying valid sample.
- Assert reset for 1 cycle midway through the 3rd period of a lock sequence → all outputs return to 0 the next cycle. The first period_valid after reset needs 5 fresh rising edges.
